// File: rtl/alu_control_mdu.sv
// RV32IM ALU-control decoder plus the start/step/last/done sequencer for the iterative MDU.
// Define ALU_CTRL_M_EXT_EN to build M-op decode and the MDU FSM; otherwise M ops decode as illegal.
module alu_control_mdu #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = $clog2(MDU_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       flush_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] ALU_Op_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] ALU_Operation_o,
  output logic       illegal_o,
  output logic       stall_o,
  output logic [2:0] mdu_op_o,
  output logic       mdu_start_o,
  output logic       mdu_step_o,
  output logic       mdu_last_o,
  output logic       mdu_done_o
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

`ifdef ALU_CTRL_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  logic [3:0] alu_op;
  logic       illegal;
  logic       r_type;

  assign r_type = (ALU_Op_i == 3'b000);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (ALU_Op_i)
      3'b000, 3'b001: begin
        case (funct3_i)
          3'b000:  alu_op = (r_type && funct7_i == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = (funct7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        // I-type only carries a funct7 field on the shift-immediate forms.
        if (r_type) begin
          if (funct7_i == F7_MULDIV)
            illegal = !M_EXT;
          else if (funct7_i == F7_ALT)
            illegal = !(funct3_i == 3'b000 || funct3_i == 3'b101);
          else if (funct7_i != F7_BASE)
            illegal = 1'b1;
        end else if (funct3_i == 3'b001) begin
          illegal = (funct7_i != F7_BASE);
        end else if (funct3_i == 3'b101) begin
          illegal = !(funct7_i == F7_BASE || funct7_i == F7_ALT);
        end
        if (r_type && funct7_i == F7_MULDIV) alu_op = ALU_ADD;
      end
      3'b010: alu_op = ALU_ADD;
      3'b011: begin
        case (funct3_i)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      3'b111:  alu_op = ALU_PASS;
      default: illegal = 1'b1;
    endcase
    if (illegal) alu_op = ALU_ADD;
  end

  assign ALU_Operation_o = alu_op;
  assign illegal_o       = illegal;

`ifdef ALU_CTRL_M_EXT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mdu_op_q, mdu_op_d;
  logic             m_op;
  logic             start;

  assign m_op  = valid_i && r_type && (funct7_i == F7_MULDIV);
  assign start = (state_q == IDLE) && m_op && !flush_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mdu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mdu_op_q <= mdu_op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_op_d = mdu_op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = CNT_W'(MDU_CYCLES - 1);
          mdu_op_d = funct3_i;
        end
      end
      RUN: begin
        // A flush wins over reaching the final iteration.
        if (flush_i)
          state_d = IDLE;
        else if (cnt_q == '0)
          state_d = DONE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mdu_start_o = 1'b0;
    mdu_step_o  = 1'b0;
    mdu_last_o  = 1'b0;
    mdu_done_o  = 1'b0;
    stall_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // State is already IDLE under reset; gating keeps these low while reset is held.
        mdu_start_o = start && !reset;
        stall_o     = m_op && !reset;
      end
      RUN: begin
        mdu_step_o = 1'b1;
        mdu_last_o = (cnt_q == '0);
        stall_o    = 1'b1;
      end
      DONE:    mdu_done_o = !flush_i;
      default: ;
    endcase
  end

  assign mdu_op_o = mdu_op_q;
`else
  assign stall_o     = 1'b0;
  assign mdu_op_o    = 3'b000;
  assign mdu_start_o = 1'b0;
  assign mdu_step_o  = 1'b0;
  assign mdu_last_o  = 1'b0;
  assign mdu_done_o  = 1'b0;
`endif

endmodule
